// File: rtl/merge8to128_pkg.sv
// Shared constants, types and byte-order helper for the byte/block packing datapath.
// Byte order: slot 0 is the most significant byte of the block. The splitters use
// the same order.
package merge8to128_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int BLOCK_W     = 128;
    localparam int WORD_W      = 32;
    localparam int BYTE_W      = 8;
    localparam int BLOCK_CW    = 5;

    // Byte count of a block, 0..BLOCK_BYTES
    typedef logic [BLOCK_CW-1:0] byte_cnt_t;

    // FILL: gathering bytes; PEND: a finished block waits in the assembly register
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_PEND = 1'b1
    } merge_state_e;

    // Bit offset of byte slot idx. Slot 0 maps to the top byte of the block.
    function automatic int byte_slot_lsb(input int bytes, input int idx);
        return (bytes - 1 - idx) * BYTE_W;
    endfunction

endpackage

// File: rtl/merge8to128_if.sv
// Byte-in / block-out handshake bundle for merge8to128.
// master = byte source and block consumer side, slave = the assembler.
interface merge8to128_if
    import merge8to128_pkg::*;
#(
    parameter int BYTES = BLOCK_BYTES,
    parameter int CW    = BLOCK_CW
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BYTE_W-1:0]     in_byte;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [8*BYTES-1:0]    out_block;
    logic [CW-1:0]         out_bytes;
    logic                  out_last;

    modport master (
        output in_valid, in_byte, in_last, out_ready,
        input  in_ready, out_valid, out_block, out_bytes, out_last
    );

    modport slave (
        input  in_valid, in_byte, in_last, out_ready,
        output in_ready, out_valid, out_block, out_bytes, out_last
    );
endinterface

// File: rtl/merge8to128_out_slot.sv
// Single-entry output register for finished blocks. A load and a drain may share
// an edge, so consecutive blocks flow without a bubble.
module merge_out_slot #(
    parameter int BW = 128,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [BW-1:0] i_block,
    input  logic [CW-1:0] i_bytes,
    input  logic          i_last,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [BW-1:0] o_block,
    output logic [CW-1:0] o_bytes,
    output logic          o_last,
    output logic          o_free
);

    logic          r_valid;
    logic [BW-1:0] r_block;
    logic [CW-1:0] r_bytes;
    logic          r_last;

    // Load a new block, or drop valid once the consumer takes the current one.
    // The payload fields hold until the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_block <= '0;
            r_bytes <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_block <= i_block;
            r_bytes <= i_bytes;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    // The slot can take a block at this edge if it is empty or is being drained now
    assign o_free  = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_block = r_block;
    assign o_bytes = r_bytes;
    assign o_last  = r_last;

endmodule

// File: rtl/merge8to128.sv
// Byte-to-block assembler. Bytes are packed big-endian into the assembly register.
// A closed block goes straight to the output slot when the slot is free. Otherwise
// it stays in the assembly register and byte intake stalls until the slot drains.
module merge8to128
    import merge8to128_pkg::*;
#(
    parameter int BYTES = BLOCK_BYTES,
    parameter int CW    = BLOCK_CW
) (
    input  logic         clk,
    input  logic         rst_n,
    merge8to128_if.slave bus
);

    localparam int            BW        = 8 * BYTES;
    localparam logic [CW-1:0] LAST_SLOT = CW'(BYTES - 1);

    merge_state_e  r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next, w_cnt_inc;
    logic [BW-1:0] r_asm, w_asm_next, w_merged;
    logic [CW-1:0] r_pend_bytes, w_pend_bytes_next;
    logic          r_pend_last, w_pend_last_next;

    logic          w_in_ready, w_accept, w_close, w_free;
    logic          w_load, w_load_last;
    logic [BW-1:0] w_load_block;
    logic [CW-1:0] w_load_bytes;
    logic          w_out_valid, w_out_last;
    logic [BW-1:0] w_out_block;
    logic [CW-1:0] w_out_bytes;

    assign w_in_ready = (r_state == ST_FILL);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_close    = w_accept && ((r_cnt == LAST_SLOT) || bus.in_last);
    assign w_cnt_inc  = r_cnt + 1'b1;

    // Merge the incoming byte into slot r_cnt. Slots below keep gathered bytes.
    // Slots above are zeroed, which also clears data left from the previous block.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_slot
            localparam logic [CW-1:0] SLOT = CW'(gi);
            localparam int            LSB  = byte_slot_lsb(BYTES, gi);
            assign w_merged[LSB +: BYTE_W] =
                (r_cnt == SLOT) ? bus.in_byte :
                (r_cnt >  SLOT) ? r_asm[LSB +: BYTE_W] : '0;
        end
    endgenerate

    // State register: assembly buffer, byte count and the pending block's metadata
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_FILL;
            r_cnt        <= '0;
            r_asm        <= '0;
            r_pend_bytes <= '0;
            r_pend_last  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_asm        <= w_asm_next;
            r_pend_bytes <= w_pend_bytes_next;
            r_pend_last  <= w_pend_last_next;
        end
    end

    // Next state: accept and merge bytes, close blocks, and decide between a direct
    // load into the output slot and parking the block until the slot drains
    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_asm_next        = r_asm;
        w_pend_bytes_next = r_pend_bytes;
        w_pend_last_next  = r_pend_last;
        w_load            = 1'b0;
        w_load_block      = w_merged;
        w_load_bytes      = w_cnt_inc;
        w_load_last       = bus.in_last;
        case (r_state)
            ST_FILL: begin
                if (w_close) begin
                    w_cnt_next = '0;
                    if (w_free) begin
                        w_load = 1'b1;
                    end else begin
                        w_asm_next        = w_merged;
                        w_pend_bytes_next = w_cnt_inc;
                        w_pend_last_next  = bus.in_last;
                        w_state_next      = ST_PEND;
                    end
                end else if (w_accept) begin
                    w_asm_next = w_merged;
                    w_cnt_next = w_cnt_inc;
                end
            end
            ST_PEND: begin
                if (w_out_valid && bus.out_ready) begin
                    w_load       = 1'b1;
                    w_load_block = r_asm;
                    w_load_bytes = r_pend_bytes;
                    w_load_last  = r_pend_last;
                    w_cnt_next   = '0;
                    w_state_next = ST_FILL;
                end
            end
            default: begin
                w_state_next = ST_FILL;
            end
        endcase
    end

    merge_out_slot #(
        .BW (BW),
        .CW (CW)
    ) u_out_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_block (w_load_block),
        .i_bytes (w_load_bytes),
        .i_last  (w_load_last),
        .i_ready (bus.out_ready),
        .o_valid (w_out_valid),
        .o_block (w_out_block),
        .o_bytes (w_out_bytes),
        .o_last  (w_out_last),
        .o_free  (w_free)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_block = w_out_block;
    assign bus.out_bytes = w_out_bytes;
    assign bus.out_last  = w_out_last;

endmodule

// File: tb/tb_merge8to128.sv
// Directed bench for merge8to128. A reference model of the byte packing pushes
// expected blocks as bytes are driven. The output monitor pops and compares each
// block as it is handed over.
module tb_merge8to128;
    import merge8to128_pkg::*;

    typedef struct packed {
        logic [BLOCK_W-1:0] blk;
        byte_cnt_t          bytes;
        logic               last;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    merge8to128_if bus_if ();

    merge8to128 u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    exp_t               sb_q[$];
    int                 n_cmp = 0;
    int                 n_err = 0;
    logic [BLOCK_W-1:0] m_blk = '0;
    int                 m_cnt = 0;

    task automatic check(input string tag, input logic [BLOCK_W-1:0] obs,
                         input logic [BLOCK_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one byte, hold it until accepted, and update the packing model
    task automatic send_byte(input logic [7:0] b, input logic last);
        int   guard;
        exp_t e;
        guard = 0;
        bus_if.in_valid = 1'b1;
        bus_if.in_byte  = b;
        bus_if.in_last  = last;
        while (bus_if.in_ready !== 1'b1 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) begin
            check("in_ready_timeout", {127'b0, bus_if.in_ready}, 128'd1);
            bus_if.in_valid = 1'b0;
            bus_if.in_last  = 1'b0;
            return;
        end
        m_blk[BLOCK_W-1-8*m_cnt -: 8] = b;
        m_cnt++;
        if (m_cnt == BLOCK_BYTES || last) begin
            e.blk   = m_blk;
            e.bytes = byte_cnt_t'(m_cnt);
            e.last  = last;
            sb_q.push_back(e);
            m_blk = '0;
            m_cnt = 0;
        end
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        bus_if.in_last  = 1'b0;
    endtask

    // Output monitor: one line per delivered block, plus a hold check under backpressure
    logic               p_hold = 1'b0;
    logic [BLOCK_W-1:0] p_blk;
    byte_cnt_t          p_bytes;
    logic               p_last;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n !== 1'b1) begin
            p_hold = 1'b0;
        end else begin
            if (p_hold) begin
                check("hold_valid", {127'b0, bus_if.out_valid}, 128'd1);
                check("hold_block", bus_if.out_block, p_blk);
                check("hold_meta", {bus_if.out_bytes, bus_if.out_last},
                      {p_bytes, p_last});
            end
            if (bus_if.out_valid === 1'b1 && bus_if.out_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_block", 128'd1, 128'd0);
                end else begin
                    e = sb_q.pop_front();
                    $display("block %h bytes %0d last %0d", bus_if.out_block,
                             bus_if.out_bytes, bus_if.out_last);
                    check("sb_block", bus_if.out_block, e.blk);
                    check("sb_bytes", {123'b0, bus_if.out_bytes}, {123'b0, e.bytes});
                    check("sb_last", {127'b0, bus_if.out_last}, {127'b0, e.last});
                end
            end
            p_hold  = (bus_if.out_valid === 1'b1) && (bus_if.out_ready === 1'b0);
            p_blk   = bus_if.out_block;
            p_bytes = bus_if.out_bytes;
            p_last  = bus_if.out_last;
        end
    end

    // Source protocol: an unaccepted byte stays valid with unchanged data
    logic       pr_pending = 1'b0;
    logic [7:0] pr_byte;
    logic       pr_last;
    always @(posedge clk) begin
        if (rst_n === 1'b1 && pr_pending) begin
            check("protocol_hold", {119'b0, bus_if.in_valid, bus_if.in_byte, bus_if.in_last},
                  {119'b0, 1'b1, pr_byte, pr_last});
        end
        pr_pending = (rst_n === 1'b1) && (bus_if.in_valid === 1'b1) &&
                     (bus_if.in_ready !== 1'b1);
        pr_byte    = bus_if.in_byte;
        pr_last    = bus_if.in_last;
    end

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.in_byte   = 8'h00;
        bus_if.in_last   = 1'b0;
        bus_if.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check("rst_out_valid", {127'b0, bus_if.out_valid}, 128'd0);
        check("rst_out_block", bus_if.out_block, 128'd0);
        check("rst_out_bytes", {123'b0, bus_if.out_bytes}, 128'd0);
        check("rst_out_last", {127'b0, bus_if.out_last}, 128'd0);
        check("rst_in_ready", {127'b0, bus_if.in_ready}, 128'd1);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full block 0x00..0x0F, visible one cycle after the last handshake
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
        check("full_valid", {127'b0, bus_if.out_valid}, 128'd1);
        check("full_block", bus_if.out_block, 128'h000102030405060708090A0B0C0D0E0F);
        check("full_bytes", {123'b0, bus_if.out_bytes}, 128'd16);
        check("full_last", {127'b0, bus_if.out_last}, 128'd0);
        check("full_w0", {96'b0, bus_if.out_block[BLOCK_W-1 -: WORD_W]}, 128'h00010203);

        // Partial flush, then a single-byte message starting at the top slot
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b1);
        check("part_block", bus_if.out_block, 128'hAABBCC00_00000000_00000000_00000000);
        check("part_bytes", {123'b0, bus_if.out_bytes}, 128'd3);
        check("part_last", {127'b0, bus_if.out_last}, 128'd1);
        send_byte(8'h5A, 1'b1);
        check("one_block", bus_if.out_block, 128'h5A000000_00000000_00000000_00000000);
        check("one_bytes", {123'b0, bus_if.out_bytes}, 128'd1);
        check("one_last", {127'b0, bus_if.out_last}, 128'd1);
        @(posedge clk);
        #1;
        check("drain_valid", {127'b0, bus_if.out_valid}, 128'd0);

        // Backpressure: 32 bytes with the consumer stalled
        bus_if.out_ready = 1'b0;
        for (int i = 0; i < 32; i++) send_byte(8'(i), 1'b0);
        check("bp_in_ready", {127'b0, bus_if.in_ready}, 128'd0);
        check("bp_block0", bus_if.out_block, 128'h000102030405060708090A0B0C0D0E0F);
        repeat (3) @(posedge clk);
        #1;
        check("bp_in_ready_hold", {127'b0, bus_if.in_ready}, 128'd0);
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_block1_valid", {127'b0, bus_if.out_valid}, 128'd1);
        check("bp_block1", bus_if.out_block, 128'h101112131415161718191A1B1C1D1E1F);
        check("bp_in_ready_back", {127'b0, bus_if.in_ready}, 128'd1);
        @(posedge clk);
        #1;
        check("bp_drained", {127'b0, bus_if.out_valid}, 128'd0);

        // Closing byte accepted on the same edge the slot drains
        bus_if.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 15; i++) send_byte(8'(8'h50 + i), 1'b0);
        bus_if.out_ready = 1'b1;
        send_byte(8'h5F, 1'b0);
        check("same_in_ready", {127'b0, bus_if.in_ready}, 128'd1);
        check("same_valid", {127'b0, bus_if.out_valid}, 128'd1);
        check("same_block", bus_if.out_block, 128'h505152535455565758595A5B5C5D5E5F);
        @(posedge clk);
        #1;

        // Reset mid-block with a held block: everything is discarded
        bus_if.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(8'(8'h60 + i), 1'b0);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h70 + i), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_valid", {127'b0, bus_if.out_valid}, 128'd0);
        check("mrst_block", bus_if.out_block, 128'd0);
        check("mrst_in_ready", {127'b0, bus_if.in_ready}, 128'd1);
        sb_q.delete();
        m_blk = '0;
        m_cnt = 0;
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), 1'b0);
        check("mrst_block_after", bus_if.out_block, 128'h202122232425262728292A2B2C2D2E2F);
        check("mrst_bytes_after", {123'b0, bus_if.out_bytes}, 128'd16);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 128'(sb_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
